// File: rtl/obstacle_pkg.sv
// rtl/obstacle_pkg.sv - shared widths, state encoding and selection helpers for the obstacle scheduler
package obstacle_pkg;

  localparam int NUM_OBST = 4;
  localparam int IDX_W    = 2;
  localparam int TIMER_W  = 30;
  localparam int ROUND_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_START  = 3'd2,
    ST_RUN    = 3'd3,
    ST_PAUSE  = 3'd4,
    ST_WIN    = 3'd5
  } state_t;

  // Fibonacci LFSR, taps for x^8 + x^6 + x^5 + x^4 + 1
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  function automatic logic [NUM_OBST-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_OBST-1:0] r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// rtl/cycle_timer.sv - clearable up-counter that saturates at a terminal count and flags expiry
module cycle_timer
  import obstacle_pkg::*;
#(
  parameter int W = TIMER_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] terminal,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + W'(1);
    end
  end

  // Expiry is only meaningful while the owning state is counting.
  assign expired = enable && (count == terminal);

endmodule

// File: rtl/obstacle_scheduler.sv
// rtl/obstacle_scheduler.sv - game sequencer picking pseudo-random obstacles with pause and watchdog timing
module obstacle_scheduler
  import obstacle_pkg::*;
#(
  parameter int         PAUSE_CYCLES   = 65000000,
  parameter int         TIMEOUT_CYCLES = 650000000,
  parameter int         ROUNDS_TO_WIN  = 10,
  parameter logic [7:0] LFSR_SEED      = 8'hA5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                game_start,
  input  logic                game_over,
  input  logic [NUM_OBST-1:0] obstacle_done,
  output logic [NUM_OBST-1:0] obstacle_start,
  output logic [NUM_OBST-1:0] obstacle_en,
  output logic [ROUND_W-1:0]  round_cnt,
  output logic                timeout_flag,
  output logic                victory,
  output logic                busy
);

  localparam logic [TIMER_W-1:0] PAUSE_TC = TIMER_W'(PAUSE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] WD_TC    = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ROUND_W-1:0] WIN_CNT  = ROUND_W'(ROUNDS_TO_WIN);

  state_t              state, state_n;
  logic [7:0]          lfsr, lfsr_n, lfsr_adv;
  logic [IDX_W-1:0]    cur_idx, idx_n, pick;
  logic [ROUND_W-1:0]  round_n;
  logic [NUM_OBST-1:0] start_n, en_n;
  logic                tflag_n, vic_n;
  logic                pause_expired, wd_expired;

  cycle_timer #(.W(TIMER_W)) u_pause_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    ((state != ST_PAUSE) || game_over),
    .enable   (state == ST_PAUSE),
    .terminal (PAUSE_TC),
    .expired  (pause_expired)
  );

  cycle_timer #(.W(TIMER_W)) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clear    ((state != ST_RUN) || game_over),
    .enable   (state == ST_RUN),
    .terminal (WD_TC),
    .expired  (wd_expired)
  );

  // cur_idx doubles as the "previous obstacle" when the next one is picked.
  always_comb begin
    lfsr_adv = lfsr_next(lfsr);
    pick     = lfsr_adv[IDX_W-1:0];
    if (pick == cur_idx) begin
      pick = pick + IDX_W'(1);
    end
  end

  always_comb begin
    state_n = state;
    lfsr_n  = lfsr;
    idx_n   = cur_idx;
    round_n = round_cnt;
    start_n = '0;
    en_n    = '0;
    tflag_n = 1'b0;
    vic_n   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (game_start) begin
          state_n = ST_SELECT;
          round_n = '0;
        end
      end
      ST_SELECT: begin
        lfsr_n  = lfsr_adv;
        idx_n   = pick;
        start_n = onehot(pick);
        en_n    = onehot(pick);
        state_n = ST_START;
      end
      ST_START: begin
        en_n    = onehot(cur_idx);
        state_n = ST_RUN;
      end
      ST_RUN: begin
        // A done arriving on the expiry cycle counts as a clean finish.
        if (obstacle_done[cur_idx]) begin
          state_n = ST_PAUSE;
          round_n = round_cnt + ROUND_W'(1);
        end else if (wd_expired) begin
          state_n = ST_PAUSE;
          round_n = round_cnt + ROUND_W'(1);
          tflag_n = 1'b1;
        end else begin
          en_n = onehot(cur_idx);
        end
      end
      ST_PAUSE: begin
        if (pause_expired) begin
          if (round_cnt == WIN_CNT) begin
            state_n = ST_WIN;
            vic_n   = 1'b1;
          end else begin
            state_n = ST_SELECT;
          end
        end
      end
      ST_WIN: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
    if (game_over) begin
      state_n = ST_IDLE;
      lfsr_n  = lfsr;
      idx_n   = cur_idx;
      round_n = round_cnt;
      start_n = '0;
      en_n    = '0;
      tflag_n = 1'b0;
      vic_n   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      lfsr           <= LFSR_SEED;
      cur_idx        <= '0;
      round_cnt      <= '0;
      obstacle_start <= '0;
      obstacle_en    <= '0;
      timeout_flag   <= 1'b0;
      victory        <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state          <= state_n;
      lfsr           <= lfsr_n;
      cur_idx        <= idx_n;
      round_cnt      <= round_n;
      obstacle_start <= start_n;
      obstacle_en    <= en_n;
      timeout_flag   <= tflag_n;
      victory        <= vic_n;
      busy           <= (state_n != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_obstacle_scheduler.sv
// tb/tb_obstacle_scheduler.sv - self-checking bench for obstacle_scheduler
module tb_obstacle_scheduler;

  localparam int P  = 4;
  localparam int TO = 16;
  localparam int RW = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       game_start = 1'b0;
  logic       game_over = 1'b0;
  logic [3:0] obstacle_done = 4'b0;
  logic [3:0] obstacle_start, obstacle_en;
  logic [7:0] round_cnt;
  logic       timeout_flag, victory, busy;

  obstacle_scheduler #(
    .PAUSE_CYCLES   (P),
    .TIMEOUT_CYCLES (TO),
    .ROUNDS_TO_WIN  (RW),
    .LFSR_SEED      (8'hA5)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .game_start     (game_start),
    .game_over      (game_over),
    .obstacle_done  (obstacle_done),
    .obstacle_start (obstacle_start),
    .obstacle_en    (obstacle_en),
    .round_cnt      (round_cnt),
    .timeout_flag   (timeout_flag),
    .victory        (victory),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, gs, go, busy;
    logic [3:0] st, en;
    logic [7:0] rc;
  } vec_t;

  vec_t vecs[12];

  int         checks = 0;
  int         errors = 0;
  logic [7:0] m_lfsr = 8'hA5;
  logic [1:0] m_prev = 2'd0;
  logic [3:0] exp_mask = 4'b0;
  logic [3:0] last_start = 4'b0;
  int         m_round = 0;
  logic       noise_on = 1'b0;
  logic       drive_sel = 1'b0;
  logic       mon_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      check("en_onehot", $countones(obstacle_en) <= 1, 1);
      check("start_only_with_en", (obstacle_start == 4'b0) || (obstacle_start == obstacle_en), 1);
    end
  end

  task automatic apply_done();
    obstacle_done = (noise_on ? (4'($urandom) & ~exp_mask) : 4'b0) | (drive_sel ? exp_mask : 4'b0);
  endtask

  task automatic tick();
    @(negedge clk);
    apply_done();
  endtask

  // Selection model: 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, never repeat the previous pick.
  task automatic predict();
    logic [1:0] idx;
    m_lfsr   = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    idx      = m_lfsr[1:0];
    if (idx == m_prev) idx = idx + 2'd1;
    m_prev   = idx;
    exp_mask = 4'b0001 << idx;
  endtask

  task automatic begin_game();
    game_start = 1'b1;
    tick();
    game_start = 1'b0;
    check("busy_after_start", busy, 1);
    check("start_not_yet", obstacle_start, 0);
    check("round_cleared", round_cnt, 0);
    m_round = 0;
    predict();
    tick();
  endtask

  // kind: 0 done at RUN cycle k, 1 watchdog timeout, 2 done on expiry cycle, 3 game_over+game_start at k
  task automatic play_round(input int kind, input int k, output bit ended);
    bit fired;
    check("start_pulse", obstacle_start, exp_mask);
    check("en_at_start", obstacle_en, exp_mask);
    if (last_start != 4'b0) check("idx_changed", obstacle_start != last_start, 1);
    last_start = obstacle_start;
    fired = 1'b0;
    for (int c = 0; c < TO && !fired; c++) begin
      tick();
      check("run_en", obstacle_en, exp_mask);
      check("run_start_low", obstacle_start, 0);
      check("run_no_timeout", timeout_flag, 0);
      if (kind == 1 && c == TO - 1) begin
        fired = 1'b1;
      end else if (((kind == 0 || kind == 3) && c == k) || (kind == 2 && c == TO - 1)) begin
        fired = 1'b1;
        if (kind == 3) begin
          game_over  = 1'b1;
          game_start = 1'b1;
        end else begin
          drive_sel = 1'b1;
          apply_done();
        end
      end
    end
    tick();
    drive_sel  = 1'b0;
    game_over  = 1'b0;
    game_start = 1'b0;
    apply_done();
    check("exit_en_low", obstacle_en, 0);
    check("exit_start_low", obstacle_start, 0);
    if (kind == 3) begin
      check("abort_idle", busy, 0);
      check("abort_round_held", round_cnt, m_round);
      check("abort_no_victory", victory, 0);
      check("abort_no_timeout", timeout_flag, 0);
      repeat (3) begin
        tick();
        check("abort_stays_idle", busy, 0);
        check("abort_en_low", obstacle_en, 0);
      end
      ended = 1'b1;
    end else begin
      m_round++;
      check("round_inc", round_cnt, m_round);
      check("busy_pause", busy, 1);
      check("timeout_pulse", timeout_flag, kind == 1);
      for (int p = 1; p < P; p++) begin
        tick();
        check("pause_en_low", obstacle_en, 0);
        check("timeout_single", timeout_flag, 0);
        check("pause_busy", busy, 1);
        check("pause_no_victory", victory, 0);
      end
      tick();
      if (m_round == RW) begin
        check("victory_pulse", victory, 1);
        check("victory_round", round_cnt, RW);
        tick();
        check("victory_single", victory, 0);
        check("idle_after_win", busy, 0);
        check("round_held", round_cnt, RW);
        ended = 1'b1;
      end else begin
        check("select_no_start", obstacle_start, 0);
        check("select_busy", busy, 1);
        predict();
        tick();
        ended = 1'b0;
      end
    end
  endtask

  initial begin
    bit ended;
    int sel, kind;

    //           rst   gs    go    busy  start  en     round
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 8'd0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 8'd0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 8'd0};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 8'd0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 4'h0, 8'd0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 4'h4, 4'h4, 8'd0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h4, 8'd0};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 8'd0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 4'h0, 8'd0};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 8'd0};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 8'd0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 8'd0};

    for (int i = 0; i < 12; i++) begin
      rst        = vecs[i].rst;
      game_start = vecs[i].gs;
      game_over  = vecs[i].go;
      tick();
      check($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
      check($sformatf("vec%0d_start", i), obstacle_start, vecs[i].st);
      check($sformatf("vec%0d_en", i), obstacle_en, vecs[i].en);
      check($sformatf("vec%0d_round", i), round_cnt, vecs[i].rc);
      check($sformatf("vec%0d_victory", i), victory, 0);
      check($sformatf("vec%0d_timeout", i), timeout_flag, 0);
    end
    game_start = 1'b0;
    game_over  = 1'b0;
    mon_on     = 1'b1;
    noise_on   = 1'b1;

    // Full game: done at RUN cycle 5, a timeout, then done coinciding with expiry.
    begin_game();
    play_round(0, 5, ended);
    play_round(1, 0, ended);
    play_round(2, 0, ended);
    check("directed_game_won", ended, 1);

    // Reset after a win clears the held round count and restarts the LFSR.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_round_clear", round_cnt, 0);
    check("rst_busy_low", busy, 0);
    m_lfsr     = 8'hA5;
    m_prev     = 2'd0;
    last_start = 4'b0;
    exp_mask   = 4'b0;
    tick();

    // Abort in RUN with game_start also high.
    begin_game();
    play_round(0, 2, ended);
    play_round(3, 4, ended);

    // Randomised games against the model.
    for (int g = 0; g < 8; g++) begin
      begin_game();
      ended = 1'b0;
      for (int r = 0; r < RW + 1 && !ended; r++) begin
        sel  = $urandom_range(0, 9);
        kind = (sel < 6) ? 0 : (sel < 8) ? 1 : (sel < 9) ? 2 : 3;
        play_round(kind, $urandom_range(0, TO - 2), ended);
      end
      check("game_ended", ended, 1);
      repeat ($urandom_range(1, 4)) tick();
    end

    mon_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/obstacle_scheduler.md
OBSTACLE_SCHEDULER -- requirements
Module: obstacle_scheduler

Interface
REQ-001 Parameter PAUSE_CYCLES, default 65000000, sets the idle gap between obstacles in clk cycles (1 s at 65 MHz).
REQ-002 Parameter TIMEOUT_CYCLES, default 650000000, sets the watchdog limit for one obstacle run in clk cycles.
REQ-003 Parameter ROUNDS_TO_WIN, default 10, range 1..255, sets the number of completed obstacles that yields victory.
REQ-004 Parameter LFSR_SEED, default 8'hA5, nonzero, sets the reset value of the selection LFSR.
REQ-005 clk  in  1  system clock; all state changes on the rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 game_start  in  1  level/pulse; starts a game when sampled in IDLE.
REQ-008 game_over  in  1  abort request; highest priority in every state.
REQ-009 obstacle_done  in  4  per-obstacle completion flag; only the selected bit is sampled.
REQ-010 obstacle_start  out  4  one-hot single-cycle start pulse to the selected obstacle.
REQ-011 obstacle_en  out  4  one-hot level enable of the selected obstacle while it runs.
REQ-012 round_cnt  out  8  count of obstacles finished in the current game.
REQ-013 timeout_flag  out  1  single-cycle pulse on watchdog expiry.
REQ-014 victory  out  1  single-cycle pulse when ROUNDS_TO_WIN is reached.
REQ-015 busy  out  1  high in every state except IDLE.

Function
REQ-016 FSM states: IDLE, SELECT, START, RUN, PAUSE, WIN; every output is registered.
REQ-017 IDLE: game_start=1 -> SELECT next cycle and round_cnt cleared to 0; otherwise stay in IDLE.
REQ-018 SELECT (1 cycle): LFSR advances once (x^8+x^6+x^5+x^4+1, Fibonacci); idx = lfsr[1:0]; if idx equals the previous obstacle, idx becomes (idx+1) mod 4; -> START.
REQ-019 START (1 cycle): obstacle_start[idx]=1, obstacle_en[idx]=1, watchdog cleared; -> RUN.
REQ-020 RUN: obstacle_en[idx] held at 1; the watchdog counts each cycle.
REQ-021 RUN exits to PAUSE and increments round_cnt in either of two cases: obstacle_done[idx]=1, or the watchdog reaching TIMEOUT_CYCLES-1, which also pulses timeout_flag.
REQ-022 In RUN, obstacle_done[idx] and watchdog expiry in the same cycle are treated as a normal done, with no timeout_flag.
REQ-023 Non-selected obstacle_done bits are ignored in every state.
REQ-024 PAUSE: obstacle_en=0; after exactly PAUSE_CYCLES cycles in PAUSE, go to WIN if round_cnt==ROUNDS_TO_WIN, else go to SELECT.
REQ-025 WIN (1 cycle): victory=1; -> IDLE; round_cnt holds its value until the next game_start.
REQ-026 game_over=1 in any state -> IDLE next cycle; obstacle_en, obstacle_start and timers cleared; round_cnt held; no victory/timeout pulse; overrides a simultaneous game_start.
REQ-027 game_start outside IDLE is ignored.
REQ-028 At most one obstacle_en bit is high at any time; obstacle_start is never high outside START.

Reset
REQ-029 rst -> state IDLE, obstacle_start=0, obstacle_en=0, round_cnt=0, timeout_flag=0, victory=0, busy=0, lfsr=LFSR_SEED, previous obstacle=0, both timers=0.
REQ-030 rst asserted mid-game has the effect of game_over plus a full reset, and takes priority over game_over.

Structure
REQ-031 Package obstacle_pkg holds NUM_OBST=4, the state encodings, and the timer width (30 bits) and round_cnt width (8 bits).
REQ-032 Sub-module cycle_timer (clear, enable, terminal-count compare, expired output) is instantiated twice: once for pause and once for the watchdog.

Verification
REQ-033 Bench parameters: PAUSE_CYCLES=4, TIMEOUT_CYCLES=16, ROUNDS_TO_WIN=3.
REQ-034 game_start pulse in IDLE -> obstacle_start one-hot pulse exactly 2 cycles later; busy=1 from the next cycle.
REQ-035 Selected obstacle_done asserted 5 cycles into RUN -> obstacle_en drops next cycle; round_cnt=1; next obstacle_start 4+2 cycles later; idx differs from previous.
REQ-036 No done for 16 RUN cycles -> timeout_flag pulses once; round_cnt increments; done and expiry injected together -> no timeout_flag.
REQ-037 Three completed obstacles -> victory pulse one cycle after the third pause ends; round_cnt=3; state IDLE.
REQ-038 game_over asserted in RUN with game_start also high -> all enables 0 next cycle; IDLE; round_cnt unchanged; no victory.
REQ-039 Non-selected done bits toggling throughout -> no effect; one-hot assertion checked every cycle.
